// File: rtl/fp16_operand_issue.sv
// Operand FIFO, magnitude ordering and special-value classification in front of a combinational fp16 adder.
// Optional FP16_ISSUE_BYPASS_EN: an idle, empty block loads a new pair straight into the issue registers.
module fp16_operand_issue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_a,
  input  logic [15:0]   in_b,
  input  logic          in_op,
  output logic [15:0]   fpa_a,
  output logic [15:0]   fpa_b,
  output logic          fpa_op,
  input  logic [15:0]   fpa_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_result,
  output logic [3:0]    out_flags,
  output logic [AW:0]   count
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [32:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [15:0]     fpa_a_q, fpa_b_q;
  logic            fpa_op_q, swapped_q, nan_q, inf_q, zero_q;
  logic            out_valid_q;
  logic [15:0]     out_result_q;
  logic [3:0]      out_flags_q;

  logic            push, pop, bypass, load, capture;
  logic [32:0]     src;
  logic [15:0]     src_a, src_b;
  logic            src_op, src_swap;
  logic [15:0]     cap_result;
  logic [3:0]      cap_flags;

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'h000);
  endfunction

  function automatic logic is_zero(input logic [15:0] x);
    return x[14:0] == 15'h0000;
  endfunction

  assign in_ready = (count_q != FULL);
  assign push     = in_valid & in_ready & ~bypass;
  assign load     = pop | bypass;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    bypass  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
`ifdef FP16_ISSUE_BYPASS_EN
        else if (in_valid) begin
          bypass  = 1'b1;
          state_d = ISSUE;
        end
`endif
      end
      ISSUE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_op, in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign src      = bypass ? {in_op, in_a, in_b} : mem_q[rd_ptr_q];
  assign src_op   = src[32];
  assign src_a    = src[31:16];
  assign src_b    = src[15:0];
  assign src_swap = src_b[14:0] > src_a[14:0];

  // Classes are symmetric in a/b, so they are taken from the unordered pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpa_a_q   <= '0;
      fpa_b_q   <= '0;
      fpa_op_q  <= 1'b0;
      swapped_q <= 1'b0;
      nan_q     <= 1'b0;
      inf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else if (load) begin
      fpa_a_q   <= src_swap ? src_b : src_a;
      fpa_b_q   <= src_swap ? src_a : src_b;
      fpa_op_q  <= src_op;
      swapped_q <= src_swap;
      nan_q     <= is_nan(src_a) | is_nan(src_b) |
                   (is_inf(src_a) & is_inf(src_b) & (src_a[15] ^ src_b[15] ^ src_op));
      inf_q     <= is_inf(src_a) | is_inf(src_b);
      zero_q    <= is_zero(src_a) & is_zero(src_b);
    end
  end

  // Adder computed b-a after a swap; a-b is its negation.
  always_comb begin
    cap_result = fpa_result;
    cap_flags  = {3'b000, swapped_q};
    if (nan_q) begin
      cap_result   = 16'h7E00;
      cap_flags[3] = 1'b1;
    end else if (inf_q) begin
      cap_flags[2] = 1'b1;
    end else if (zero_q) begin
      cap_flags[1] = 1'b1;
    end else if (swapped_q & fpa_op_q) begin
      cap_result[15] = ~fpa_result[15];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (capture) begin
      out_valid_q  <= 1'b1;
      out_result_q <= cap_result;
      out_flags_q  <= cap_flags;
    end else if (out_valid_q & out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign fpa_a      = fpa_a_q;
  assign fpa_b      = fpa_b_q;
  assign fpa_op     = fpa_op_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign count      = count_q;

endmodule
